sip_dot_acc: RTL and testbench

Pipelined, parametrised successor of the bit-parallel SIP dot unit. It multiplies N_DOT lanes of BITS_PARALLEL-bit activation/weight slices with per-beat sign control, reduces them in a registered adder tree, and accumulates shifted partial sums across beats. Multi-bit precisions are composed from low-precision slices this way. It sits between the operand-slice fetch logic and the output/requantisation stage of a PE column.

---
 rtl/sip_dot_acc_if.sv | 34 +++
 rtl/sip_dot_acc.sv | 166 ++++++++++++++++
 tb/tb_sip_dot_acc.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sip_dot_acc_if.sv
// Beat and result bus of the SIP dot-product accumulator.
// Handshake: no ready either way; every rising edge with i_Valid=1 delivers a beat, and o_Valid is a one-cycle pulse the consumer must take in that cycle.
interface sip_dot_acc_if #(
  parameter int N_DOT         = 8,
  parameter int BITS_PARALLEL = 2,
  parameter int MAX_SHIFT     = 3,
  parameter int ACC_W         = 24
);
  localparam int SH_W = (MAX_SHIFT > 0) ? $clog2(MAX_SHIFT + 1) : 1;

  logic                             i_Valid;
  logic                             i_First;
  logic                             i_Last;
  logic [N_DOT*BITS_PARALLEL-1:0]   i_Act;
  logic [N_DOT*BITS_PARALLEL-1:0]   i_Weight;
  logic                             i_SignI;
  logic                             i_SignW;
  logic [SH_W-1:0]                  i_Shift;
  logic                             o_Valid;
  logic [ACC_W-1:0]                 o_Result;
  logic                             o_Overflow;
  logic                             o_Err;
  logic                             o_DbgAcc;

  modport master (
    output i_Valid, i_First, i_Last, i_Act, i_Weight, i_SignI, i_SignW, i_Shift,
    input  o_Valid, o_Result, o_Overflow, o_Err, o_DbgAcc
  );

  modport slave (
    input  i_Valid, i_First, i_Last, i_Act, i_Weight, i_SignI, i_SignW, i_Shift,
    output o_Valid, o_Result, o_Overflow, o_Err, o_DbgAcc
  );
endinterface

// File: rtl/sip_dot_acc.sv
// Pipelined bit-parallel dot product: lane multiply, registered adder tree, shifted accumulation across beats.
// o_DbgAcc mirrors the FSM state (1 = accumulation open).
module sip_dot_acc #(
  parameter int N_DOT         = 8,
  parameter int BITS_PARALLEL = 2,
  parameter int MAX_SHIFT     = 3,
  parameter int ACC_W         = 24
) (
  input  logic         i_CLK,
  input  logic         i_RSTn,
  sip_dot_acc_if.slave bus
);
  localparam int MUL_W  = 2 * (BITS_PARALLEL + 1);
  localparam int SUM_W  = MUL_W + $clog2(N_DOT);
  localparam int SH_W   = (MAX_SHIFT > 0) ? $clog2(MAX_SHIFT + 1) : 1;
  localparam int TERM_W = ACC_W + SUM_W + BITS_PARALLEL * MAX_SHIFT;

  typedef enum logic {ST_IDLE = 1'b0, ST_ACC = 1'b1} state_t;

  logic signed [MUL_W-1:0] prod_d [N_DOT];

  for (genvar g = 0; g < N_DOT; g++) begin : g_lane
    logic [BITS_PARALLEL-1:0] a_sl;
    logic [BITS_PARALLEL-1:0] w_sl;
    logic signed [MUL_W-1:0]  a_x;
    logic signed [MUL_W-1:0]  w_x;
    assign a_sl = bus.i_Act[BITS_PARALLEL*g +: BITS_PARALLEL];
    assign w_sl = bus.i_Weight[BITS_PARALLEL*g +: BITS_PARALLEL];
    assign a_x  = {{(MUL_W-BITS_PARALLEL){bus.i_SignI & a_sl[BITS_PARALLEL-1]}}, a_sl};
    assign w_x  = {{(MUL_W-BITS_PARALLEL){bus.i_SignW & w_sl[BITS_PARALLEL-1]}}, w_sl};
    assign prod_d[g] = a_x * w_x;
  end

  logic            shift_bad;
  logic [SH_W-1:0] shift_cl;
  assign shift_bad = ({1'b0, bus.i_Shift} > (SH_W+1)'(MAX_SHIFT));
  assign shift_cl  = shift_bad ? SH_W'(MAX_SHIFT) : bus.i_Shift;

  logic                    p1_valid_q, p1_first_q, p1_last_q, p1_serr_q;
  logic [SH_W-1:0]         p1_shift_q;
  logic signed [MUL_W-1:0] p1_prod_q [N_DOT];

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      p1_valid_q <= 1'b0;
      p1_first_q <= 1'b0;
      p1_last_q  <= 1'b0;
      p1_serr_q  <= 1'b0;
      p1_shift_q <= '0;
      for (int i = 0; i < N_DOT; i++) p1_prod_q[i] <= '0;
    end else begin
      p1_valid_q <= bus.i_Valid;
      if (bus.i_Valid) begin
        p1_first_q <= bus.i_First;
        p1_last_q  <= bus.i_Last;
        p1_serr_q  <= shift_bad;
        p1_shift_q <= shift_cl;
        for (int i = 0; i < N_DOT; i++) p1_prod_q[i] <= prod_d[i];
      end
    end
  end

  logic [SUM_W-1:0] sum_d;
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N_DOT; i++) begin
      sum_d = sum_d + {{(SUM_W-MUL_W){p1_prod_q[i][MUL_W-1]}}, p1_prod_q[i]};
    end
  end

  logic             p2_valid_q, p2_first_q, p2_last_q, p2_serr_q;
  logic [SH_W-1:0]  p2_shift_q;
  logic [SUM_W-1:0] p2_sum_q;

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      p2_valid_q <= 1'b0;
      p2_first_q <= 1'b0;
      p2_last_q  <= 1'b0;
      p2_serr_q  <= 1'b0;
      p2_shift_q <= '0;
      p2_sum_q   <= '0;
    end else begin
      p2_valid_q <= p1_valid_q;
      if (p1_valid_q) begin
        p2_first_q <= p1_first_q;
        p2_last_q  <= p1_last_q;
        p2_serr_q  <= p1_serr_q;
        p2_shift_q <= p1_shift_q;
        p2_sum_q   <= sum_d;
      end
    end
  end

  // Term is built wide enough to be exact so a term alone that leaves the ACC_W range is caught.
  logic [TERM_W-1:0] term_w;
  logic [ACC_W-1:0]  term_acc;
  logic              term_ovf;
  logic [ACC_W:0]    acc_sum;
  logic              sum_ovf;
  state_t            state_q;
  logic [ACC_W-1:0]  acc_q;
  logic              ovf_q, emit_q, err_q;

  assign term_w   = {{(TERM_W-SUM_W){p2_sum_q[SUM_W-1]}}, p2_sum_q} << (BITS_PARALLEL * p2_shift_q);
  assign term_acc = term_w[ACC_W-1:0];
  assign term_ovf = ~((&term_w[TERM_W-1:ACC_W-1]) | ~(|term_w[TERM_W-1:ACC_W-1]));
  assign acc_sum  = {acc_q[ACC_W-1], acc_q} + {term_acc[ACC_W-1], term_acc};
  assign sum_ovf  = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      emit_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      emit_q <= 1'b0;
      err_q  <= 1'b0;
      if (p2_valid_q) begin
        if (p2_first_q) begin
          // A First while open abandons the running sum and restarts from this beat.
          acc_q   <= term_acc;
          ovf_q   <= term_ovf;
          err_q   <= p2_serr_q | (state_q == ST_ACC);
          emit_q  <= p2_last_q;
          state_q <= p2_last_q ? ST_IDLE : ST_ACC;
        end else if (state_q == ST_ACC) begin
          acc_q  <= acc_sum[ACC_W-1:0];
          ovf_q  <= ovf_q | term_ovf | sum_ovf;
          err_q  <= p2_serr_q;
          emit_q <= p2_last_q;
          if (p2_last_q) state_q <= ST_IDLE;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  logic             o_valid_q, o_err_q, o_ovf_q;
  logic [ACC_W-1:0] o_res_q;

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      o_valid_q <= 1'b0;
      o_err_q   <= 1'b0;
      o_ovf_q   <= 1'b0;
      o_res_q   <= '0;
    end else begin
      o_valid_q <= emit_q;
      o_err_q   <= err_q;
      if (emit_q) begin
        o_res_q <= acc_q;
        o_ovf_q <= ovf_q;
      end
    end
  end

  assign bus.o_Valid    = o_valid_q;
  assign bus.o_Result   = o_res_q;
  assign bus.o_Overflow = o_ovf_q;
  assign bus.o_Err      = o_err_q;
  assign bus.o_DbgAcc   = (state_q == ST_ACC);
endmodule

// File: tb/tb_sip_dot_acc.sv
// Directed table-driven bench for sip_dot_acc: a 24-bit and a 10-bit accumulator share one beat stream.
module tb_sip_dot_acc;
  localparam int N_DOT   = 8;
  localparam int BP      = 2;
  localparam int MAX_SH  = 3;
  localparam int ACC_W   = 24;
  localparam int ACC_W_B = 10;
  localparam int LW      = N_DOT * BP;
  localparam int LAT     = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sip_dot_acc_if #(.N_DOT(N_DOT), .BITS_PARALLEL(BP), .MAX_SHIFT(MAX_SH), .ACC_W(ACC_W))   bus_a ();
  sip_dot_acc_if #(.N_DOT(N_DOT), .BITS_PARALLEL(BP), .MAX_SHIFT(MAX_SH), .ACC_W(ACC_W_B)) bus_b ();

  sip_dot_acc #(.N_DOT(N_DOT), .BITS_PARALLEL(BP), .MAX_SHIFT(MAX_SH), .ACC_W(ACC_W))
    dut_a (.i_CLK(clk), .i_RSTn(rst_n), .bus(bus_a.slave));
  sip_dot_acc #(.N_DOT(N_DOT), .BITS_PARALLEL(BP), .MAX_SHIFT(MAX_SH), .ACC_W(ACC_W_B))
    dut_b (.i_CLK(clk), .i_RSTn(rst_n), .bus(bus_b.slave));

  assign bus_b.i_Valid  = bus_a.i_Valid;
  assign bus_b.i_First  = bus_a.i_First;
  assign bus_b.i_Last   = bus_a.i_Last;
  assign bus_b.i_Act    = bus_a.i_Act;
  assign bus_b.i_Weight = bus_a.i_Weight;
  assign bus_b.i_SignI  = bus_a.i_SignI;
  assign bus_b.i_SignW  = bus_a.i_SignW;
  assign bus_b.i_Shift  = bus_a.i_Shift;

  typedef struct {
    logic v, f, l;
    logic [1:0] sh;
    logic si, sw;
    logic [LW-1:0] act, wt;
    logic e_v;
    logic [ACC_W-1:0] e_res;
    logic e_ovf, e_err;
    logic chk_b;
    logic [ACC_W_B-1:0] b_res;
    logic b_ovf;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;
  logic [ACC_W-1:0] exp_q[$];

  function automatic vec_t mk(input int v, input int f, input int l, input int sh,
                              input int si, input int sw, input logic [LW-1:0] act,
                              input logic [LW-1:0] wt, input int e_v, input int res,
                              input int e_ovf, input int e_err, input int chk_b = 0,
                              input int bres = 0, input int b_ovf = 0);
    vec_t r;
    r.v = 1'(v);   r.f = 1'(f);   r.l = 1'(l);   r.sh = 2'(sh);
    r.si = 1'(si); r.sw = 1'(sw); r.act = act;   r.wt = wt;
    r.e_v = 1'(e_v); r.e_res = ACC_W'(res); r.e_ovf = 1'(e_ovf); r.e_err = 1'(e_err);
    r.chk_b = 1'(chk_b); r.b_res = ACC_W_B'(bres); r.b_ovf = 1'(b_ovf);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t x);
    bus_a.i_Valid  = x.v;
    bus_a.i_First  = x.f;
    bus_a.i_Last   = x.l;
    bus_a.i_Shift  = x.sh;
    bus_a.i_SignI  = x.si;
    bus_a.i_SignW  = x.sw;
    bus_a.i_Act    = x.act;
    bus_a.i_Weight = x.wt;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus_a.o_Valid), 32'd0);
    check({tag, "_result"}, 32'(bus_a.o_Result), 32'd0);
    check({tag, "_ovf"}, 32'(bus_a.o_Overflow), 32'd0);
    check({tag, "_err"}, 32'(bus_a.o_Err), 32'd0);
    check({tag, "_dbg"}, 32'(bus_a.o_DbgAcc), 32'd0);
    check({tag, "_b_valid"}, 32'(bus_b.o_Valid), 32'd0);
  endtask

  vec_t tbl[$];
  vec_t pipe_q[$];
  vec_t idle_v, cur, ev;
  logic [ACC_W-1:0] held_res;
  logic held_ovf;

  initial begin
    idle_v = mk(0, 0, 0, 0, 0, 0, '0, '0, 0, 0, 0, 0);
    // v f l sh si sw act wt | valid result ovf err | chk_b b_result b_ovf
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 1, 72, 0, 0, 1, 72, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 16'hAAAA, 16'hFFFF, 1, -48, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 1, 16'hAAAA, 16'hAAAA, 1, 32, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 1, 360, 0, 0, 1, 360, 0));
    tbl.push_back(mk(0, 1, 1, 3, 1, 1, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'hE4E4, 16'h55FF, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h1234, 16'h5678, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h5555, 16'h5555, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 2, 0, 0, 16'h5555, 16'hAAAA, 1, 264, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 16'hFFFF, 16'hFFFF, 1, -24, 0, 0));
    tbl.push_back(mk(1, 1, 1, 3, 0, 0, 16'hFFFF, 16'hFFFF, 1, 4608, 0, 0, 1, -512, 1));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 16'hFFFF, 16'hFFFF, 1, 576, 0, 0, 1, -448, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 1, 72, 0, 0, 1, 72, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 1, 16'h0000, 16'h0000, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 16'hAAAA, 16'hFFFF, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 16'h5555, 16'h5555, 1, 8, 0, 1));

    // clock / reset
    rst_n = 1'b0;
    drive(idle_v);
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // table stream: expectations for beat k are observed LAT negedges after it is driven
    held_res = '0;
    held_ovf = 1'b0;
    for (int cyc = 0; cyc < tbl.size() + LAT; cyc++) begin
      if (pipe_q.size() == LAT) begin
        ev = pipe_q.pop_front();
        check("valid", 32'(bus_a.o_Valid), 32'(ev.e_v));
        check("err", 32'(bus_a.o_Err), 32'(ev.e_err));
        if (ev.e_v) begin
          held_res = ev.e_res;
          held_ovf = ev.e_ovf;
        end
        check("result_held", 32'(bus_a.o_Result), 32'(held_res));
        check("ovf_held", 32'(bus_a.o_Overflow), 32'(held_ovf));
        if (ev.chk_b) begin
          check("b_valid", 32'(bus_b.o_Valid), 32'd1);
          check("b_result", 32'(bus_b.o_Result), 32'(ev.b_res));
          check("b_ovf", 32'(bus_b.o_Overflow), 32'(ev.b_ovf));
        end
      end else begin
        check("fill_valid", 32'(bus_a.o_Valid), 32'd0);
      end
      if (bus_a.o_Valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_unexpected: got o_Valid=1 result %0h expected no result", bus_a.o_Result);
        end else begin
          check("sb_result", 32'(bus_a.o_Result), 32'(exp_q.pop_front()));
        end
      end
      cur = (cyc < tbl.size()) ? tbl[cyc] : idle_v;
      if (cur.e_v) exp_q.push_back(cur.e_res);
      drive(cur);
      pipe_q.push_back(cur);
      @(negedge clk);
    end
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    // reset while a Last beat sits in P2
    drive(mk(1, 1, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(1, 0, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0));
    @(negedge clk);
    drive(idle_v);
    @(negedge clk);
    check("dbg_open_pre_rst", 32'(bus_a.o_DbgAcc), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(bus_a.o_Valid), 32'd0);
      check("post_rst_err", 32'(bus_a.o_Err), 32'd0);
    end

    // fresh single beat after reset: lanes 2*3 unsigned -> 48
    drive(mk(1, 1, 1, 0, 0, 0, 16'hAAAA, 16'hFFFF, 0, 0, 0, 0));
    @(negedge clk);
    drive(idle_v);
    repeat (LAT - 1) @(negedge clk);
    check("fresh_valid", 32'(bus_a.o_Valid), 32'd1);
    check("fresh_result", 32'(bus_a.o_Result), 32'd48);
    check("fresh_ovf", 32'(bus_a.o_Overflow), 32'd0);
    check("fresh_err", 32'(bus_a.o_Err), 32'd0);
    @(negedge clk);
    check("fresh_pulse_end", 32'(bus_a.o_Valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
